// File: rtl/bg_row_loader.sv
// Background name-table row loader: copies one 8-word map row from ROM into a name-table row.
// Optional `define BG_LOADER_WAIT_VBLANK_EN restricts name-table writes to vblank.
module bg_row_loader #(
  parameter int MAP_ADDR_W = 12,
  parameter int NT_ROWS    = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vblank,
  input  logic                  load_req,
  input  logic [MAP_ADDR_W-4:0] load_map_row,
  input  logic [4:0]            load_nt_row,
  input  logic                  load_commit,
  output logic                  load_busy,
  output logic                  load_done,
  output logic                  load_err,
  output logic [MAP_ADDR_W-1:0] map_rom_addr,
  input  logic [31:0]           map_rom_data,
  output logic                  nt_we,
  output logic [7:0]            nt_waddr,
  output logic [31:0]           nt_wdata,
  output logic [4:0]            scroll_row
);

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, DONE} state_t;

  localparam logic [5:0] NT_ROWS_L = 6'(NT_ROWS);

  state_t                state_q;
  logic [MAP_ADDR_W-4:0] map_row_q;
  logic [4:0]            nt_row_q;
  logic                  commit_q;
  logic [2:0]            rd_idx_q;
  logic [2:0]            wr_idx_q;
  logic                  valid_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  err_q;
  logic [4:0]            scroll_q;
  logic                  go;
  logic                  row_ok;

  function automatic logic [2:0] sat_inc(input logic [2:0] v);
    return (v == 3'd7) ? 3'd7 : v + 3'd1;
  endfunction

`ifdef BG_LOADER_WAIT_VBLANK_EN
  assign go = vblank;
`else
  logic unused_vblank;
  assign unused_vblank = vblank;
  assign go = 1'b1;
`endif

  assign row_ok = ({1'b0, load_nt_row} < NT_ROWS_L);

  // valid_q marks that map_rom_data currently holds the word for wr_idx_q
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      map_row_q <= '0;
      nt_row_q  <= '0;
      commit_q  <= 1'b0;
      rd_idx_q  <= '0;
      wr_idx_q  <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      scroll_q  <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          rd_idx_q <= '0;
          wr_idx_q <= '0;
          valid_q  <= 1'b0;
          if (load_req) begin
            if (row_ok) begin
              map_row_q <= load_map_row;
              nt_row_q  <= load_nt_row;
              commit_q  <= load_commit;
              busy_q    <= 1'b1;
              state_q   <= FETCH;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        FETCH: begin
          if (go) begin
            rd_idx_q <= sat_inc(rd_idx_q);
            valid_q  <= 1'b1;
            state_q  <= STREAM;
          end
        end
        STREAM: begin
          if (!go) begin
            // Stall: re-aim the ROM at the word still waiting to be written
            rd_idx_q <= wr_idx_q;
            valid_q  <= 1'b0;
          end else begin
            rd_idx_q <= sat_inc(rd_idx_q);
            valid_q  <= 1'b1;
            if (valid_q) begin
              wr_idx_q <= wr_idx_q + 3'd1;
              if (wr_idx_q == 3'd7) begin
                state_q <= DONE;
                valid_q <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                if (commit_q) scroll_q <= nt_row_q;
              end
            end
          end
        end
        DONE: begin
          rd_idx_q <= '0;
          wr_idx_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign load_busy    = busy_q;
  assign load_done    = done_q;
  assign load_err     = err_q;
  assign map_rom_addr = {map_row_q, rd_idx_q};
  assign nt_we        = valid_q & go;
  assign nt_waddr     = {nt_row_q, wr_idx_q};
  assign nt_wdata     = map_rom_data;
  assign scroll_row   = scroll_q;

endmodule

// File: tb/tb_bg_row_loader.sv
// Directed bench for bg_row_loader with a registered map ROM model (word = 0xC0DE0000 | addr).
module tb_bg_row_loader;
  logic        clk = 1'b0;
  logic        rst, vblank, load_req, load_commit;
  logic [8:0]  load_map_row;
  logic [4:0]  load_nt_row;
  logic        load_busy, load_done, load_err, nt_we;
  logic [11:0] map_rom_addr;
  logic [31:0] map_rom_data, nt_wdata;
  logic [7:0]  nt_waddr;
  logic [4:0]  scroll_row;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  always @(posedge clk) map_rom_data <= 32'hC0DE_0000 | {20'd0, map_rom_addr};

  bg_row_loader #(.MAP_ADDR_W(12), .NT_ROWS(30)) dut (
    .clk(clk), .rst(rst), .vblank(vblank), .load_req(load_req),
    .load_map_row(load_map_row), .load_nt_row(load_nt_row), .load_commit(load_commit),
    .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
    .map_rom_addr(map_rom_addr), .map_rom_data(map_rom_data),
    .nt_we(nt_we), .nt_waddr(nt_waddr), .nt_wdata(nt_wdata), .scroll_row(scroll_row)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept a load, vblank low during cycles [sf, sf+sl), checking every write in order
  task automatic run_load(input logic [8:0] mrow, input logic [4:0] nrow, input logic commit,
                          input int sf, input int sl, output int done_at, output int n_wr);
    load_map_row = mrow;
    load_nt_row  = nrow;
    load_commit  = commit;
    load_req     = 1'b1;
    vblank       = !(sf <= 0 && 0 < sf + sl);
    n_wr    = 0;
    done_at = -1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      load_req = 1'b0;
      vblank   = !(c >= sf && c < sf + sl);
      #1;
      if (nt_we) begin
        chk("run_waddr", {24'd0, nt_waddr}, {24'd0, nrow, 3'(n_wr)});
        chk("run_wdata", nt_wdata, 32'hC0DE_0000 | {20'd0, mrow, 3'(n_wr)});
        n_wr++;
      end
      if (load_done) begin
        done_at = c;
        break;
      end
    end
    vblank = 1'b1;
  endtask

  initial begin
    int done_at, n_wr, seen;
    rst = 1'b1; vblank = 1'b1; load_req = 1'b0; load_commit = 1'b0;
    load_map_row = '0; load_nt_row = '0;
    tick(); tick();
    chk("rst_busy",   load_busy, 0);
    chk("rst_done",   load_done, 0);
    chk("rst_err",    load_err, 0);
    chk("rst_we",     nt_we, 0);
    chk("rst_waddr",  nt_waddr, 0);
    chk("rst_addr",   map_rom_addr, 0);
    chk("rst_scroll", scroll_row, 0);
    rst = 1'b0;
    tick();

    // Basic load, map row 5 -> nt row 3, with a busy-time request that must be ignored
    load_map_row = 9'd5; load_nt_row = 5'd3; load_commit = 1'b0; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    chk("c1_busy", load_busy, 1);
    chk("c1_we",   nt_we, 0);
    chk("c1_addr", map_rom_addr, 12'h028);
    for (int k = 2; k <= 9; k++) begin
      if (k == 3) begin load_req = 1'b1; load_nt_row = 5'd7; load_map_row = 9'd1; end
      if (k == 6) load_req = 1'b0;
      tick();
      chk("str_we",    nt_we, 1);
      chk("str_busy",  load_busy, 1);
      chk("str_waddr", nt_waddr, 8'h18 + 8'(k - 2));
      chk("str_wdata", nt_wdata, 32'hC0DE_0028 + 32'(k - 2));
    end
    tick();
    chk("c10_done",   load_done, 1);
    chk("c10_busy",   load_busy, 0);
    chk("c10_we",     nt_we, 0);
    chk("c10_scroll", scroll_row, 0);
    tick();
    chk("c11_done", load_done, 0);
    chk("c11_busy", load_busy, 0);
    tick();
    chk("c12_busy", load_busy, 0);

    // Out-of-range destination rows are rejected
    for (int r = 30; r <= 31; r++) begin
      load_nt_row = 5'(r); load_req = 1'b1;
      tick();
      load_req = 1'b0;
      chk("rej_err",  load_err, 1);
      chk("rej_busy", load_busy, 0);
      chk("rej_we",   nt_we, 0);
      tick();
      chk("rej_err_off", load_err, 0);
      chk("rej_busy2",   load_busy, 0);
      chk("rej_we2",     nt_we, 0);
    end

    // Commit to last legal row, then a non-committing load leaves scroll alone
    run_load(9'd2, 5'd29, 1'b1, 100, 0, done_at, n_wr);
    chk("cm_done_at", done_at, 10);
    chk("cm_nwr",     n_wr, 8);
    chk("cm_scroll",  scroll_row, 29);
    tick();
    chk("cm_scroll2", scroll_row, 29);
    run_load(9'd4, 5'd4, 1'b0, 100, 0, done_at, n_wr);
    chk("nc_done_at", done_at, 10);
    chk("nc_scroll",  scroll_row, 29);
    tick();

`ifdef BG_LOADER_WAIT_VBLANK_EN
    // vblank low for cycles 5..8, right after word 2 lands on cycle 4
    run_load(9'd3, 5'd1, 1'b0, 5, 4, done_at, n_wr);
    chk("vb_nwr",     n_wr, 8);
    chk("vb_done_at", done_at, 15);
`else
    // vblank held low throughout must not slow the load down
    run_load(9'd3, 5'd1, 1'b0, 0, 100, done_at, n_wr);
    chk("vb_nwr",     n_wr, 8);
    chk("vb_done_at", done_at, 10);
`endif
    tick();

    // Reset in the middle of a load
    load_map_row = 9'd1; load_nt_row = 5'd2; load_commit = 1'b1; load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (int k = 2; k <= 5; k++) tick();
    chk("mid_we", nt_we, 1);
    rst = 1'b1;
    tick();
    chk("rr_we",     nt_we, 0);
    chk("rr_busy",   load_busy, 0);
    chk("rr_done",   load_done, 0);
    chk("rr_scroll", scroll_row, 0);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (load_done || nt_we || load_busy) seen++;
    end
    chk("rr_quiet", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
